scr1_tapc_gen2: RTL and testbench

- Parametrised next-generation JTAG TAP controller running entirely in the system clock domain.
- Oversamples pre-synchronised TCK/TMS/TDI, runs the IEEE 1149.1 16-state FSM on detected TCK edges, and holds a width-configurable IR.
- Implements IDCODE and BYPASS internally.
- Exposes NUM_USER_DR external DR chains through a generic select/capture/shift/update interface. Sits between the pad synchronisers and the debug transport module.

---
 rtl/scr1_tapc_pkg.sv | 47 ++++
 rtl/scr1_tapc_gen2_fsm.sv | 85 ++++++++
 rtl/scr1_tapc_gen2.sv | 194 +++++++++++++++++++
 tb/tb_scr1_tapc_gen2.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/scr1_tapc_pkg.sv
// ----------------------------------------------------------------------------
// scr1_tapc_pkg
// Shared definitions for the system-clock-domain JTAG TAP controller:
//   - type_scr1_tap_state_e : IEEE 1149.1 16-state TAP FSM encoding
//   - scr1_tap_ir_all_ones   : all-ones (BYPASS) opcode for an IR of any width
//   - SCR1_TAP_IDCODE_RISCV_SC / SCR1_TAP_INSTRUCTION_WIDTH : default constants
// ----------------------------------------------------------------------------
package scr1_tapc_pkg;

   localparam int unsigned SCR1_TAP_INSTRUCTION_WIDTH = 4;
   localparam logic [31:0] SCR1_TAP_IDCODE_RISCV_SC   = 32'hC0D1DEB1;

   typedef enum logic [3:0] {
      SCR1_TAP_STATE_RESET       = 4'd0,
      SCR1_TAP_STATE_IDLE        = 4'd1,
      SCR1_TAP_STATE_DR_SEL_SCAN = 4'd2,
      SCR1_TAP_STATE_DR_CAPTURE  = 4'd3,
      SCR1_TAP_STATE_DR_SHIFT    = 4'd4,
      SCR1_TAP_STATE_DR_EXIT1    = 4'd5,
      SCR1_TAP_STATE_DR_PAUSE    = 4'd6,
      SCR1_TAP_STATE_DR_EXIT2    = 4'd7,
      SCR1_TAP_STATE_DR_UPDATE   = 4'd8,
      SCR1_TAP_STATE_IR_SEL_SCAN = 4'd9,
      SCR1_TAP_STATE_IR_CAPTURE  = 4'd10,
      SCR1_TAP_STATE_IR_SHIFT    = 4'd11,
      SCR1_TAP_STATE_IR_EXIT1    = 4'd12,
      SCR1_TAP_STATE_IR_PAUSE    = 4'd13,
      SCR1_TAP_STATE_IR_EXIT2    = 4'd14,
      SCR1_TAP_STATE_IR_UPDATE   = 4'd15
   } type_scr1_tap_state_e;

   // Returns the all-ones opcode for an IR of the given width (width <= 32),
   // zero-extended to 32 bits so callers can truncate to their own IR width.
   function automatic logic [31:0] scr1_tap_ir_all_ones(input int unsigned width);
      logic [31:0] v;
      v = 32'h0000_0000;
      for (int unsigned i = 0; i < 32; i++) begin
         if (i < width) begin
            v[i] = 1'b1;
         end else begin
            v[i] = 1'b0;
         end
      end
      return v;
   endfunction

endpackage : scr1_tapc_pkg

// File: rtl/scr1_tapc_gen2_fsm.sv
// ----------------------------------------------------------------------------
// scr1_tapc_gen2_fsm
// TCK edge detector plus the IEEE 1149.1 TAP state machine, all clocked by the
// system clock. The FSM advances only on a detected TCK rising edge.
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   i_tck, i_tms : synchronised TCK level and TMS
//   o_state      : current TAP state
//   o_rise       : TCK rising edge seen this clk (combinational)
//   o_fall       : TCK falling edge seen this clk (combinational)
//   o_tap_reset  : high while in TEST_LOGIC_RESET, registered with the state
// ----------------------------------------------------------------------------
module scr1_tapc_gen2_fsm
   import scr1_tapc_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_tck,
   input  logic                 i_tms,
   output type_scr1_tap_state_e o_state,
   output logic                 o_rise,
   output logic                 o_fall,
   output logic                 o_tap_reset
);

   logic                 r_tck_q;
   type_scr1_tap_state_e r_state;
   type_scr1_tap_state_e w_next_state;
   logic                 r_tap_reset;

   // TCK level delayed by one clk for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tck_q <= 1'b0;
      end else begin
         r_tck_q <= i_tck;
      end
   end

   assign o_rise = i_tck & ~r_tck_q;
   assign o_fall = ~i_tck & r_tck_q;

   // Standard 1149.1 next-state table, evaluated against TMS.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         SCR1_TAP_STATE_RESET:       w_next_state = i_tms ? SCR1_TAP_STATE_RESET       : SCR1_TAP_STATE_IDLE;
         SCR1_TAP_STATE_IDLE:        w_next_state = i_tms ? SCR1_TAP_STATE_DR_SEL_SCAN : SCR1_TAP_STATE_IDLE;
         SCR1_TAP_STATE_DR_SEL_SCAN: w_next_state = i_tms ? SCR1_TAP_STATE_IR_SEL_SCAN : SCR1_TAP_STATE_DR_CAPTURE;
         SCR1_TAP_STATE_DR_CAPTURE:  w_next_state = i_tms ? SCR1_TAP_STATE_DR_EXIT1    : SCR1_TAP_STATE_DR_SHIFT;
         SCR1_TAP_STATE_DR_SHIFT:    w_next_state = i_tms ? SCR1_TAP_STATE_DR_EXIT1    : SCR1_TAP_STATE_DR_SHIFT;
         SCR1_TAP_STATE_DR_EXIT1:    w_next_state = i_tms ? SCR1_TAP_STATE_DR_UPDATE   : SCR1_TAP_STATE_DR_PAUSE;
         SCR1_TAP_STATE_DR_PAUSE:    w_next_state = i_tms ? SCR1_TAP_STATE_DR_EXIT2    : SCR1_TAP_STATE_DR_PAUSE;
         SCR1_TAP_STATE_DR_EXIT2:    w_next_state = i_tms ? SCR1_TAP_STATE_DR_UPDATE   : SCR1_TAP_STATE_DR_SHIFT;
         SCR1_TAP_STATE_DR_UPDATE:   w_next_state = i_tms ? SCR1_TAP_STATE_DR_SEL_SCAN : SCR1_TAP_STATE_IDLE;
         SCR1_TAP_STATE_IR_SEL_SCAN: w_next_state = i_tms ? SCR1_TAP_STATE_RESET       : SCR1_TAP_STATE_IR_CAPTURE;
         SCR1_TAP_STATE_IR_CAPTURE:  w_next_state = i_tms ? SCR1_TAP_STATE_IR_EXIT1    : SCR1_TAP_STATE_IR_SHIFT;
         SCR1_TAP_STATE_IR_SHIFT:    w_next_state = i_tms ? SCR1_TAP_STATE_IR_EXIT1    : SCR1_TAP_STATE_IR_SHIFT;
         SCR1_TAP_STATE_IR_EXIT1:    w_next_state = i_tms ? SCR1_TAP_STATE_IR_UPDATE   : SCR1_TAP_STATE_IR_PAUSE;
         SCR1_TAP_STATE_IR_PAUSE:    w_next_state = i_tms ? SCR1_TAP_STATE_IR_EXIT2    : SCR1_TAP_STATE_IR_PAUSE;
         SCR1_TAP_STATE_IR_EXIT2:    w_next_state = i_tms ? SCR1_TAP_STATE_IR_UPDATE   : SCR1_TAP_STATE_IR_SHIFT;
         SCR1_TAP_STATE_IR_UPDATE:   w_next_state = i_tms ? SCR1_TAP_STATE_DR_SEL_SCAN : SCR1_TAP_STATE_IDLE;
         default:                    w_next_state = SCR1_TAP_STATE_RESET;
      endcase
   end

   // State register; tap_reset is derived from the next state so it moves
   // in the same clk as the state itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= SCR1_TAP_STATE_RESET;
         r_tap_reset <= 1'b1;
      end else if (o_rise) begin
         r_state     <= w_next_state;
         r_tap_reset <= (w_next_state == SCR1_TAP_STATE_RESET);
      end else begin
         r_state     <= r_state;
         r_tap_reset <= r_tap_reset;
      end
   end

   assign o_state     = r_state;
   assign o_tap_reset = r_tap_reset;

endmodule : scr1_tapc_gen2_fsm

// File: rtl/scr1_tapc_gen2.sv
// ----------------------------------------------------------------------------
// scr1_tapc_gen2
// JTAG TAP controller running in the system clock domain. Holds the IR, the
// internal IDCODE and BYPASS registers, the TDO mux, and a generic interface
// to NUM_USER_DR external DR chains (opcodes USER_IR_BASE + k).
// Ports:
//   clk, rst              : system clock, synchronous active-high reset
//   tck_i, tms_i, tdi_i   : synchronised JTAG pins
//   tdo_o, tdo_en_o       : serial data out and its drive enable (set on TCK fall)
//   tap_reset_o           : high while in TEST_LOGIC_RESET
//   ir_o                  : current instruction
//   dr_sel_o              : one-hot user chain select
//   dr_capture_o/shift_o/update_o : one-clk strobes, not qualified by dr_sel_o
//   dr_tdi_o              : TDI forwarded to user chains
//   dr_tdo_i              : LSB of each user chain
// ----------------------------------------------------------------------------
module scr1_tapc_gen2
   import scr1_tapc_pkg::*;
#(
   parameter int unsigned      IR_W         = SCR1_TAP_INSTRUCTION_WIDTH,
   parameter logic [31:0]      IDCODE_VAL   = SCR1_TAP_IDCODE_RISCV_SC,
   parameter logic [IR_W-1:0]  IR_IDCODE    = IR_W'(4'hE),
   parameter logic [IR_W-1:0]  USER_IR_BASE = IR_W'(4'h3),
   parameter int unsigned      NUM_USER_DR  = 8
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   tck_i,
   input  logic                   tms_i,
   input  logic                   tdi_i,
   output logic                   tdo_o,
   output logic                   tdo_en_o,
   output logic                   tap_reset_o,
   output logic [IR_W-1:0]        ir_o,
   output logic [NUM_USER_DR-1:0] dr_sel_o,
   output logic                   dr_capture_o,
   output logic                   dr_shift_o,
   output logic                   dr_update_o,
   output logic                   dr_tdi_o,
   input  logic [NUM_USER_DR-1:0] dr_tdo_i
);

   // Parameter sanity: user opcodes must sit below IDCODE, and IDCODE must not
   // collide with the mandatory all-ones BYPASS opcode.
   if (IR_W < 2) begin : g_chk_ir_w
      $error("scr1_tapc_gen2: IR_W must be at least 2");
   end
   if ((NUM_USER_DR < 1) || (NUM_USER_DR > 16)) begin : g_chk_num_dr
      $error("scr1_tapc_gen2: NUM_USER_DR must be in 1..16");
   end
   if ((32'(USER_IR_BASE) + NUM_USER_DR) > 32'(IR_IDCODE)) begin : g_chk_user_range
      $error("scr1_tapc_gen2: user opcode range overlaps IDCODE");
   end
   if (IR_IDCODE == IR_W'(scr1_tap_ir_all_ones(IR_W))) begin : g_chk_idcode
      $error("scr1_tapc_gen2: IDCODE opcode must not be all-ones");
   end

   type_scr1_tap_state_e   w_state;
   logic                   w_rise;
   logic                   w_fall;
   logic                   w_tap_reset;

   logic [IR_W-1:0]        r_ir;
   logic [IR_W-1:0]        r_ir_shift;
   logic [31:0]            r_idcode_shift;
   logic                   r_bypass;
   logic                   r_tdo;
   logic                   r_tdo_en;
   logic                   r_dr_capture;
   logic                   r_dr_shift;
   logic                   r_dr_update;

   logic [IR_W-1:0]        w_user_off;
   logic                   w_is_user;
   logic [NUM_USER_DR-1:0] w_dr_sel;
   logic                   w_sel_lsb;

   scr1_tapc_gen2_fsm u_fsm (
      .clk         (clk),
      .rst         (rst),
      .i_tck       (tck_i),
      .i_tms       (tms_i),
      .o_state     (w_state),
      .o_rise      (w_rise),
      .o_fall      (w_fall),
      .o_tap_reset (w_tap_reset)
   );

   // User chain decode: offset from the base opcode, range-checked so that
   // opcodes below the base (which wrap) and above the last chain fall to BYPASS.
   always_comb begin
      w_user_off = r_ir - USER_IR_BASE;
      w_is_user  = (r_ir >= USER_IR_BASE) && (32'(w_user_off) < NUM_USER_DR);
      w_dr_sel   = '0;
      for (int unsigned k = 0; k < NUM_USER_DR; k++) begin
         w_dr_sel[k] = w_is_user && (32'(w_user_off) == k);
      end
   end

   // Serial source for TDO during DR_SHIFT.
   always_comb begin
      w_sel_lsb = r_bypass;
      if (r_ir == IR_IDCODE) begin
         w_sel_lsb = r_idcode_shift[0];
      end else if (w_is_user) begin
         w_sel_lsb = |(w_dr_sel & dr_tdo_i);
      end else begin
         w_sel_lsb = r_bypass;
      end
   end

   // Rise-edge datapath: IR capture/shift and internal DR capture/shift.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ir_shift     <= '0;
         r_idcode_shift <= 32'h0000_0000;
         r_bypass       <= 1'b0;
      end else if (w_rise) begin
         case (w_state)
            SCR1_TAP_STATE_IR_CAPTURE: r_ir_shift <= IR_W'(2'b01);
            SCR1_TAP_STATE_IR_SHIFT:   r_ir_shift <= {tdi_i, r_ir_shift[IR_W-1:1]};
            SCR1_TAP_STATE_DR_CAPTURE: begin
               r_idcode_shift <= IDCODE_VAL;
               r_bypass       <= 1'b0;
            end
            SCR1_TAP_STATE_DR_SHIFT: begin
               r_idcode_shift <= {tdi_i, r_idcode_shift[31:1]};
               r_bypass       <= tdi_i;
            end
            default: begin
               r_ir_shift     <= r_ir_shift;
            end
         endcase
      end else begin
         r_ir_shift     <= r_ir_shift;
      end
   end

   // One-clk DR strobes: capture/shift on rise, update on fall.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dr_capture <= 1'b0;
         r_dr_shift   <= 1'b0;
         r_dr_update  <= 1'b0;
      end else begin
         r_dr_capture <= w_rise && (w_state == SCR1_TAP_STATE_DR_CAPTURE);
         r_dr_shift   <= w_rise && (w_state == SCR1_TAP_STATE_DR_SHIFT);
         r_dr_update  <= w_fall && (w_state == SCR1_TAP_STATE_DR_UPDATE);
      end
   end

   // Instruction register: loaded on fall in IR_UPDATE, forced to IDCODE in RESET.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ir <= IR_IDCODE;
      end else if (w_fall && (w_state == SCR1_TAP_STATE_IR_UPDATE)) begin
         r_ir <= r_ir_shift;
      end else if (w_fall && (w_state == SCR1_TAP_STATE_RESET)) begin
         r_ir <= IR_IDCODE;
      end else begin
         r_ir <= r_ir;
      end
   end

   // TDO and its enable change only on TCK fall; TDO holds outside shift states.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tdo    <= 1'b0;
         r_tdo_en <= 1'b0;
      end else if (w_fall) begin
         r_tdo_en <= (w_state == SCR1_TAP_STATE_IR_SHIFT) ||
                     (w_state == SCR1_TAP_STATE_DR_SHIFT);
         case (w_state)
            SCR1_TAP_STATE_IR_SHIFT: r_tdo <= r_ir_shift[0];
            SCR1_TAP_STATE_DR_SHIFT: r_tdo <= w_sel_lsb;
            default:                 r_tdo <= r_tdo;
         endcase
      end else begin
         r_tdo    <= r_tdo;
         r_tdo_en <= r_tdo_en;
      end
   end

   assign tdo_o        = r_tdo;
   assign tdo_en_o     = r_tdo_en;
   assign tap_reset_o  = w_tap_reset;
   assign ir_o         = r_ir;
   assign dr_sel_o     = w_dr_sel;
   assign dr_capture_o = r_dr_capture;
   assign dr_shift_o   = r_dr_shift;
   assign dr_update_o  = r_dr_update;
   assign dr_tdi_o     = tdi_i;

endmodule : scr1_tapc_gen2

// File: tb/tb_scr1_tapc_gen2.sv
// ----------------------------------------------------------------------------
// tb_scr1_tapc_gen2
// Directed testbench for scr1_tapc_gen2 with default parameters. TCK is driven
// as a slow level (4 clk high, 4 clk low); outputs are sampled on clk negedges.
// ----------------------------------------------------------------------------
module tb_scr1_tapc_gen2;

   logic       clk;
   logic       rst;
   logic       tck_i;
   logic       tms_i;
   logic       tdi_i;
   logic       tdo_o;
   logic       tdo_en_o;
   logic       tap_reset_o;
   logic [3:0] ir_o;
   logic [7:0] dr_sel_o;
   logic       dr_capture_o;
   logic       dr_shift_o;
   logic       dr_update_o;
   logic       dr_tdi_o;
   logic [7:0] dr_tdo_i;

   int n_vec;
   int n_err;
   int cap_cnt;
   int shf_cnt;
   int upd_cnt;

   scr1_tapc_gen2 dut (
      .clk          (clk),
      .rst          (rst),
      .tck_i        (tck_i),
      .tms_i        (tms_i),
      .tdi_i        (tdi_i),
      .tdo_o        (tdo_o),
      .tdo_en_o     (tdo_en_o),
      .tap_reset_o  (tap_reset_o),
      .ir_o         (ir_o),
      .dr_sel_o     (dr_sel_o),
      .dr_capture_o (dr_capture_o),
      .dr_shift_o   (dr_shift_o),
      .dr_update_o  (dr_update_o),
      .dr_tdi_o     (dr_tdi_o),
      .dr_tdo_i     (dr_tdo_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe pulse counters (count clks each strobe is high).
   always @(posedge clk) begin
      if (dr_capture_o) cap_cnt <= cap_cnt + 1;
      if (dr_shift_o)   shf_cnt <= shf_cnt + 1;
      if (dr_update_o)  upd_cnt <= upd_cnt + 1;
   end

   task automatic tck_cycle(input logic tms, input logic tdi);
      @(negedge clk);
      tms_i = tms;
      tdi_i = tdi;
      tck_i = 1'b1;
      repeat (4) @(negedge clk);
      tck_i = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   // From RUN_TEST_IDLE: scan n bits through IR or DR, return to IDLE.
   // tdo_v[k] is TDO after the k-th fall in the shift state; pat[k] drives
   // user chain 2 for that fall (other chains get the opposite value).
   task automatic scan(input bit is_ir, input int n, input logic [63:0] tdi_v,
                       input logic [63:0] pat, output logic [63:0] tdo_v,
                       output int en_bad);
      tdo_v  = 64'h0;
      en_bad = 0;
      tck_cycle(1'b1, 1'b0);
      if (is_ir) tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      dr_tdo_i = pat[0] ? 8'h04 : 8'hFB;
      tck_cycle(1'b0, 1'b0);
      tdo_v[0] = tdo_o;
      if (tdo_en_o !== 1'b1) en_bad++;
      for (int i = 0; i < n; i++) begin
         if (i < n - 1) dr_tdo_i = pat[i+1] ? 8'h04 : 8'hFB;
         tck_cycle((i == n - 1), tdi_v[i]);
         if (i < n - 1) begin
            tdo_v[i+1] = tdo_o;
            if (tdo_en_o !== 1'b1) en_bad++;
         end else begin
            if (tdo_en_o !== 1'b0) en_bad++;
         end
      end
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_vec++; if (tap_reset_o !== 1'b1) begin n_err++; $display("FAIL reset_tap_reset got %b want 1", tap_reset_o); end
      n_vec++; if (ir_o !== 4'hE) begin n_err++; $display("FAIL reset_ir got %h want e", ir_o); end
      n_vec++; if (tdo_en_o !== 1'b0) begin n_err++; $display("FAIL reset_tdo_en got %b want 0", tdo_en_o); end
      n_vec++; if (tdo_o !== 1'b0) begin n_err++; $display("FAIL reset_tdo got %b want 0", tdo_o); end
      n_vec++; if ({dr_capture_o, dr_shift_o, dr_update_o} !== 3'b000) begin n_err++; $display("FAIL reset_strobes got %b want 000", {dr_capture_o, dr_shift_o, dr_update_o}); end
      n_vec++; if (dr_sel_o !== 8'h00) begin n_err++; $display("FAIL reset_dr_sel got %h want 00", dr_sel_o); end
      tck_cycle(1'b0, 1'b0);
      n_vec++; if (tap_reset_o !== 1'b0) begin n_err++; $display("FAIL idle_tap_reset got %b want 0", tap_reset_o); end
   endtask

   task automatic test_idcode;
      logic [63:0] tv;
      int eb, c0, s0, u0;
      c0 = cap_cnt; s0 = shf_cnt; u0 = upd_cnt;
      scan(1'b0, 32, 64'h0, 64'h0, tv, eb);
      n_vec++; if (tv[31:0] !== 32'hC0D1DEB1) begin n_err++; $display("FAIL idcode_tdo got %h want c0d1deb1", tv[31:0]); end
      n_vec++; if (eb !== 0) begin n_err++; $display("FAIL idcode_tdo_en bad_samples %0d want 0", eb); end
      n_vec++; if (cap_cnt - c0 !== 1) begin n_err++; $display("FAIL idcode_capture_cnt got %0d want 1", cap_cnt - c0); end
      n_vec++; if (shf_cnt - s0 !== 32) begin n_err++; $display("FAIL idcode_shift_cnt got %0d want 32", shf_cnt - s0); end
      n_vec++; if (upd_cnt - u0 !== 1) begin n_err++; $display("FAIL idcode_update_cnt got %0d want 1", upd_cnt - u0); end
      n_vec++; if (tdo_en_o !== 1'b0) begin n_err++; $display("FAIL idcode_tdo_en_after got %b want 0", tdo_en_o); end
   endtask

   task automatic test_user_chain;
      logic [63:0] tv;
      int eb;
      scan(1'b1, 4, 64'h5, 64'h0, tv, eb);
      n_vec++; if (tv[3:0] !== 4'b0001) begin n_err++; $display("FAIL ir_capture_tdo got %b want 0001", tv[3:0]); end
      n_vec++; if (eb !== 0) begin n_err++; $display("FAIL ir_tdo_en bad_samples %0d want 0", eb); end
      n_vec++; if (ir_o !== 4'h5) begin n_err++; $display("FAIL ir_load got %h want 5", ir_o); end
      n_vec++; if (dr_sel_o !== 8'b0000_0100) begin n_err++; $display("FAIL user_dr_sel got %b want 00000100", dr_sel_o); end
      scan(1'b0, 6, 64'h2A, 64'h2D, tv, eb);
      n_vec++; if (tv[5:0] !== 6'b101101) begin n_err++; $display("FAIL user_tdo got %b want 101101", tv[5:0]); end
      n_vec++; if (dr_sel_o !== 8'b0000_0100) begin n_err++; $display("FAIL user_dr_sel_after got %b want 00000100", dr_sel_o); end
   endtask

   task automatic test_bypass;
      logic [63:0] tv;
      int eb;
      logic [3:0] ops [2];
      ops[0] = 4'hF;
      ops[1] = 4'h0;
      for (int j = 0; j < 2; j++) begin
         scan(1'b1, 4, {60'h0, ops[j]}, 64'h0, tv, eb);
         n_vec++; if (ir_o !== ops[j]) begin n_err++; $display("FAIL bypass_ir got %h want %h", ir_o, ops[j]); end
         n_vec++; if (dr_sel_o !== 8'h00) begin n_err++; $display("FAIL bypass_dr_sel got %h want 00", dr_sel_o); end
         scan(1'b0, 5, 64'h0D, 64'h1F, tv, eb);
         n_vec++; if (tv[4:0] !== 5'b11010) begin n_err++; $display("FAIL bypass_tdo op %h got %b want 11010", ops[j], tv[4:0]); end
         n_vec++; if (eb !== 0) begin n_err++; $display("FAIL bypass_tdo_en bad_samples %0d want 0", eb); end
      end
   endtask

   task automatic test_tlr;
      // IDLE -> DR_SEL -> IR_SEL -> IR_CAPTURE -> IR_EXIT1 -> IR_PAUSE
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      // Four TMS=1 rises pass through IR_UPDATE (loads captured 0001)
      for (int i = 0; i < 4; i++) tck_cycle(1'b1, 1'b0);
      n_vec++; if (tap_reset_o !== 1'b0) begin n_err++; $display("FAIL tlr_4_rises got %b want 0", tap_reset_o); end
      n_vec++; if (ir_o !== 4'h1) begin n_err++; $display("FAIL tlr_ir_via_update got %h want 1", ir_o); end
      tck_cycle(1'b1, 1'b0);
      n_vec++; if (tap_reset_o !== 1'b1) begin n_err++; $display("FAIL tlr_5_rises got %b want 1", tap_reset_o); end
      n_vec++; if (ir_o !== 4'hE) begin n_err++; $display("FAIL tlr_ir got %h want e", ir_o); end
      tck_cycle(1'b0, 1'b0);
   endtask

   task automatic test_midscan_reset;
      logic [63:0] tv;
      int eb;
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'b1);
      n_vec++; if (tdo_en_o !== 1'b1) begin n_err++; $display("FAIL midscan_tdo_en got %b want 1", tdo_en_o); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_vec++; if (tap_reset_o !== 1'b1) begin n_err++; $display("FAIL midscan_rst_state got %b want 1", tap_reset_o); end
      n_vec++; if (tdo_en_o !== 1'b0) begin n_err++; $display("FAIL midscan_rst_tdo_en got %b want 0", tdo_en_o); end
      n_vec++; if (dut.r_idcode_shift !== 32'h0) begin n_err++; $display("FAIL midscan_rst_idcode got %h want 0", dut.r_idcode_shift); end
      tck_cycle(1'b0, 1'b0);
      scan(1'b0, 32, 64'h0, 64'h0, tv, eb);
      n_vec++; if (tv[31:0] !== 32'hC0D1DEB1) begin n_err++; $display("FAIL midscan_rescan got %h want c0d1deb1", tv[31:0]); end
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      cap_cnt  = 0;
      shf_cnt  = 0;
      upd_cnt  = 0;
      rst      = 1'b1;
      tck_i    = 1'b0;
      tms_i    = 1'b1;
      tdi_i    = 1'b0;
      dr_tdo_i = 8'h00;
      test_reset();
      test_idcode();
      test_user_chain();
      test_bypass();
      test_tlr();
      test_midscan_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_scr1_tapc_gen2
